// File: rtl/mb8_arbiter_pkg.sv
// Shared types and defaults for the 8-bit memory-block arbiter.
package mb8_arbiter_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_e;

    localparam int unsigned ARB_NREQ = 3;
    localparam int unsigned IW       = $clog2(ARB_NREQ);

    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/mb8_arbiter_if.sv
// Requester-side bus of the 8-bit memory-block arbiter (packed per-master fields).
interface mb8_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned ASZ  = 17,
    parameter int unsigned DSZ  = 8
) ();
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     we;
    logic [NREQ-1:0]     lock;
    logic [NREQ*ASZ-1:0] addr;
    logic [NREQ*DSZ-1:0] wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rvalid;
    logic [DSZ-1:0]      rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mb8_arbiter_rr_pick.sv
// Round-robin pick: first set bit of mask at or after ptr, wrapping modulo NREQ.
module mb8_arbiter_rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] mask,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDXW-1:0] idx,
    output logic            any
);
    int unsigned j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!any && mask[IDXW'(j)]) begin
                any                 = 1'b1;
                idx                 = IDXW'(j);
                onehot[IDXW'(j)]    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mb8_arbiter.sv
// Single-port memory-block arbiter: zero-latency issue, optional lock for
// multi-byte transfers bounded by LOCK_MAX, registered one-hot read response.
module mb8_arbiter
    import mb8_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = ARB_NREQ,
    parameter int unsigned ASZ      = 17,
    parameter int unsigned DSZ      = 8,
    parameter int unsigned PRIO0    = 1,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    mb8_arbiter_if.slave             bus,
    output logic                     mem_ce,
    output logic                     mem_we,
    output logic [ASZ-1:0]           mem_addr,
    output logic [DSZ-1:0]           mem_wdata,
    input  logic [DSZ-1:0]           mem_rdata,
    output logic [$clog2(NREQ)-1:0]  owner
);
    localparam int unsigned IDXW = $clog2(NREQ);
    localparam int unsigned CW   = $clog2(LOCK_MAX + 1);

    arb_state_e      state_q;
    logic [IDXW-1:0] owner_q, rr_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] rvalid_q;

    logic [NREQ-1:0] pick_onehot, gnt_vec;
    logic [IDXW-1:0] pick_idx, gnt_idx;
    logic            pick_any, gnt_any, prio_hit, lock_exit;

    mb8_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .mask   (bus.req),
        .ptr    (rr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        prio_hit = 1'b0;
        if (state_q == ARB_LOCKED) begin
            gnt_idx = owner_q;
            gnt_any = bus.req[owner_q];
        end else if (PRIO0 != 0 && bus.req[0]) begin
            gnt_any  = 1'b1;
            prio_hit = 1'b1;
        end else begin
            gnt_idx = pick_idx;
            gnt_any = pick_any;
        end
    end

    always_comb begin
        gnt_vec   = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDXW'(i)) begin
                gnt_vec[i] = gnt_any;
                mem_we     = gnt_any & bus.we[i];
                mem_addr   = bus.addr[i*ASZ +: ASZ];
                mem_wdata  = bus.wdata[i*DSZ +: DSZ];
            end
        end
    end

    assign mem_ce     = gnt_any;
    assign bus.gnt    = gnt_vec;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = mem_rdata;
    assign owner      = owner_q;

    // Leave the lock when the owner stops requesting, drops lock, or hits LOCK_MAX grants.
    assign lock_exit = !gnt_any || !bus.lock[owner_q] || (cnt_q >= CW'(LOCK_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= mem_we ? '0 : gnt_vec;
            unique case (state_q)
                ARB_IDLE: begin
                    if (gnt_any) begin
                        owner_q <= gnt_idx;
                        if (bus.lock[gnt_idx] && LOCK_MAX > 1) begin
                            state_q <= ARB_LOCKED;
                            cnt_q   <= CW'(1);
                        end else if (!prio_hit) begin
                            // Fixed-priority grants of req 0 leave the rotation untouched.
                            rr_q <= IDXW'(wrap_inc(32'(gnt_idx), NREQ));
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (lock_exit) begin
                        state_q <= ARB_IDLE;
                        cnt_q   <= '0;
                        rr_q    <= IDXW'(wrap_inc(32'(owner_q), NREQ));
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end
endmodule
